audio_echo_effect_mc: RTL and testbench

Multi-channel echo/feedback-delay processor with runtime-programmable delay, feedback gain and wet mix. Sits between `serial_audio_decoder` and `spdif_audio_encoder` (or any valid/ready audio stream) and generalises the stereo fixed-delay echo to N channels, with feedback, saturation and power-on buffer clearing.

---
 rtl/audio_echo_effect_mc_if.sv | 27 ++
 rtl/audio_echo_effect_mc.sv | 140 ++++++++++++++
 tb/tb_audio_echo_effect_mc.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_echo_effect_mc_if.sv
// Sample stream bundle for the echo processor: input stream (i_*) and output stream (o_*).
// The processor connects through the slave modport; the source/sink side uses master.
interface audio_echo_effect_mc_if #(
    parameter int audio_width = 16,
    parameter int channels    = 2
);
    localparam int CH_W = (channels > 1) ? $clog2(channels) : 1;

    logic                          i_valid;
    logic                          i_ready;
    logic [CH_W-1:0]               i_channel;
    logic signed [audio_width-1:0] i_audio;
    logic                          o_valid;
    logic                          o_ready;
    logic [CH_W-1:0]               o_channel;
    logic signed [audio_width-1:0] o_audio;

    modport slave (
        input  i_valid, i_channel, i_audio, o_ready,
        output i_ready, o_valid, o_channel, o_audio
    );

    modport master (
        output i_valid, i_channel, i_audio, o_ready,
        input  i_ready, o_valid, o_channel, o_audio
    );
endinterface

// File: rtl/audio_echo_effect_mc.sv
// Multi-channel feedback echo: one shared delay RAM (channel-major), cleared at reset,
// processing one interleaved sample every four cycles with saturating wet/feedback paths.
module audio_echo_effect_mc #(
    parameter int audio_width       = 16,
    parameter int channels          = 2,
    parameter int max_delay_samples = 2048,
    parameter int gain_width        = 8
) (
    input  logic                                clk,
    input  logic                                nreset,
    audio_echo_effect_mc_if.slave               bus,
    input  logic [$clog2(max_delay_samples):0]  delay,
    input  logic [gain_width-1:0]               fb_gain,
    input  logic [gain_width-1:0]               mix_gain,
    input  logic                                bypass
);
    localparam int CH_W   = (channels > 1) ? $clog2(channels) : 1;
    localparam int PTR_W  = $clog2(max_delay_samples);
    localparam int ADDR_W = CH_W + PTR_W;
    localparam int DEPTH  = channels * max_delay_samples;
    localparam int PROD_W = audio_width + gain_width + 1;
    localparam int SUM_W  = audio_width + gain_width + 2;
    localparam logic [PTR_W:0]    DMAX       = (PTR_W + 1)'(max_delay_samples);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, OUT} state_t;

    state_t                        state, next_state;
    logic [ADDR_W-1:0]             clr_addr;
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W:0]                d_frames;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CH_W-1:0]               cap_ch;
    logic signed [audio_width-1:0] cap_x;
    logic                          cap_dry;
    logic                          accept;
    logic                          dry_in;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_waddr;
    logic signed [audio_width-1:0] mem_wdata;
    logic signed [audio_width-1:0] rd_data;
    logic signed [SUM_W-1:0]       wet, fbv;
    logic signed [audio_width-1:0] y, s;
    logic signed [audio_width-1:0] mem [DEPTH];

    // Signed sample times unsigned gain, arithmetic shift gives floor(d*g / 2^gain_width).
    function automatic logic signed [SUM_W-1:0] scale(input logic signed [audio_width-1:0] d,
                                                       input logic [gain_width-1:0] g);
        logic signed [PROD_W-1:0] a, b, p;
        a = PROD_W'(d);
        b = PROD_W'($signed({1'b0, g}));
        p = a * b;
        return SUM_W'(p >>> gain_width);
    endfunction

    function automatic logic signed [audio_width-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (!v[SUM_W-1] && (|v[SUM_W-2:audio_width-1]))
            return {1'b0, {(audio_width-1){1'b1}}};
        else if (v[SUM_W-1] && !(&v[SUM_W-2:audio_width-1]))
            return {1'b1, {(audio_width-1){1'b0}}};
        else
            return v[audio_width-1:0];
    endfunction

    function automatic logic [PTR_W:0] clamp_delay(input logic [PTR_W:0] v);
        if (v == '0)
            return (PTR_W + 1)'(1);
        else if (v > DMAX)
            return DMAX;
        else
            return v;
    endfunction

    assign bus.i_ready = (state == IDLE);
    assign accept      = (state == IDLE) && bus.i_valid;
    assign dry_in      = int'(bus.i_channel) >= channels;
    // Truncating subtraction is the modulo; D == depth lands on wr_ptr itself.
    assign rd_ptr      = wr_ptr - d_frames[PTR_W-1:0];

    assign wet = scale(rd_data, mix_gain);
    assign fbv = scale(rd_data, fb_gain);
    assign y   = sat(SUM_W'(cap_x) + wet);
    assign s   = sat(SUM_W'(cap_x) + fbv);

    assign mem_we    = nreset && ((state == CLEAR) || ((state == CALC) && !cap_dry));
    assign mem_waddr = (state == CLEAR) ? clr_addr : {cap_ch, wr_ptr};
    assign mem_wdata = (state == CLEAR) ? '0 : s;

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) next_state = IDLE;
            IDLE:    if (bus.i_valid) next_state = READ;
            READ:    next_state = CALC;
            CALC:    next_state = OUT;
            OUT:     if (bus.o_ready) next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // Stage p0: accept and issue the delayed read (read happens before the CALC write).
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (accept && !dry_in) rd_data <= mem[{bus.i_channel, rd_ptr}];
        if (accept) begin
            cap_ch  <= bus.i_channel;
            cap_x   <= bus.i_audio;
            cap_dry <= dry_in;
        end
    end

    // Stage p2: CALC registers the output and advances the frame after the last channel.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= CLEAR;
            clr_addr      <= '0;
            wr_ptr        <= '0;
            d_frames      <= (PTR_W + 1)'(1);
            bus.o_valid   <= 1'b0;
            bus.o_audio   <= '0;
            bus.o_channel <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
                wr_ptr   <= '0;
            end
            if (state == CALC) begin
                bus.o_valid   <= 1'b1;
                bus.o_audio   <= (cap_dry || bypass) ? cap_x : y;
                bus.o_channel <= cap_ch;
                if (!cap_dry && (int'(cap_ch) == channels - 1)) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    d_frames <= clamp_delay(delay);
                end
            end
            if ((state == OUT) && bus.o_ready) bus.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_echo_effect_mc.sv
// Randomized bench for audio_echo_effect_mc against a frame/array model of the echo rules.
module tb_audio_echo_effect_mc;
    localparam int AW   = 16;
    localparam int CH   = 2;
    localparam int MAXD = 2048;
    localparam int GW   = 8;
    localparam int CHW  = 1;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [11:0] delay;
    logic [7:0]  fb_gain, mix_gain;
    logic        bypass;

    audio_echo_effect_mc_if #(.audio_width(AW), .channels(CH)) bus ();

    audio_echo_effect_mc #(
        .audio_width(AW), .channels(CH), .max_delay_samples(MAXD), .gain_width(GW)
    ) dut (
        .clk(clk), .nreset(nreset), .bus(bus),
        .delay(delay), .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mdl_mem [CH*MAXD];
    int mdl_wr;
    int mdl_d;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int sat_w(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH*MAXD; i++) mdl_mem[i] = 0;
        mdl_wr = 0;
        mdl_d  = 1;
    endfunction

    // One sample through the echo: read D frames back, emit, store feedback, maybe advance frame.
    function automatic int model_step(input int ch, input int x);
        int rd, d, y;
        if (ch >= CH) return x;
        rd = (mdl_wr - mdl_d + MAXD) % MAXD;
        d  = mdl_mem[ch*MAXD + rd];
        y  = bypass ? x : sat_w(x + floor_div(d * int'(mix_gain), 256));
        mdl_mem[ch*MAXD + mdl_wr] = sat_w(x + floor_div(d * int'(fb_gain), 256));
        if (ch == CH - 1) begin
            mdl_wr = (mdl_wr + 1) % MAXD;
            if (int'(delay) == 0) mdl_d = 1;
            else if (int'(delay) > MAXD) mdl_d = MAXD;
            else mdl_d = int'(delay);
        end
        return y;
    endfunction

    task automatic reset_and_clear(input int low_cycles);
        int n;
        nreset = 1'b0;
        bus.i_valid = 1'b0;
        repeat (low_cycles) @(negedge clk);
        check_val("rst_o_valid", int'(bus.o_valid), 0);
        check_val("rst_i_ready", int'(bus.i_ready), 0);
        check_val("rst_o_audio", int'(bus.o_audio), 0);
        check_val("rst_o_channel", int'(bus.o_channel), 0);
        nreset = 1'b1;
        bus.o_ready = 1'b1;
        model_reset();
        n = 0;
        while (bus.i_ready !== 1'b1 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check_val("clear_cycles", n, CH*MAXD);
    endtask

    task automatic send(input int ch, input int x, input int stall, output int got);
        int n, exp;
        n = 0;
        while (bus.i_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("i_ready_timeout", n, 0);
        bus.i_valid   = 1'b1;
        bus.i_channel = ch[CHW-1:0];
        bus.i_audio   = x[AW-1:0];
        if (stall > 0) bus.o_ready = 1'b0;
        exp = model_step(ch, x);
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 0;
        while (bus.o_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("o_valid_seen", int'(n < 20), 1);
        got = int'(bus.o_audio);
        check_val("o_audio", got, exp);
        check_val("o_channel", int'(bus.o_channel), ch);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_val("stall_o_valid", int'(bus.o_valid), 1);
            check_val("stall_o_audio", int'(bus.o_audio), exp);
            check_val("stall_o_channel", int'(bus.o_channel), ch);
            check_val("stall_i_ready", int'(bus.i_ready), 0);
            bus.o_ready = 1'b1;
        end
        @(negedge clk);
        check_val("o_valid_drop", int'(bus.o_valid), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, x0, x1, n, exp;
        bus.i_valid = 1'b0;
        bus.i_channel = '0;
        bus.i_audio = '0;
        bus.o_ready = 1'b1;
        delay = 12'd4;
        fb_gain = 8'd0;
        mix_gain = 8'd255;
        bypass = 1'b0;
        @(negedge clk);

        // Reset, clear length and first output
        reset_and_clear(3);
        send(0, 0, 0, got);
        check_val("first_out_zero", got, 0);

        // Impulse response on ch0, silent ch1
        reset_and_clear(3);
        delay = 12'd4; mix_gain = 8'd128; fb_gain = 8'd128;
        for (int f = 0; f < 10; f++) begin
            x0 = (f == 0) ? 16384 : 0;
            send(0, x0, 0, got);
            exp = (f == 0) ? 16384 : (f == 4) ? 8192 : (f == 8) ? 4096 : 0;
            check_val("impulse_ch0", got, exp);
            send(1, 0, 0, got);
            check_val("impulse_ch1", got, 0);
        end

        // Delay change 4 -> 8 between ch0 and ch1 of frame 10
        reset_and_clear(3);
        delay = 12'd4; mix_gain = 8'd200; fb_gain = 8'd90;
        for (int f = 0; f < 16; f++) begin
            x0 = int'($urandom_range(20000)) - 10000;
            x1 = int'($urandom_range(20000)) - 10000;
            send(0, x0, 0, got);
            if (f == 10) delay = 12'd8;
            send(1, x1, 0, got);
        end

        // Saturation at both rails
        delay = 12'd1; mix_gain = 8'd255; fb_gain = 8'd0;
        send(0, 0, 0, got);
        send(1, 0, 0, got);
        send(0, 30000, 0, got);
        send(1, 0, 0, got);
        send(0, 30000, 0, got);
        check_val("sat_pos", got, 32767);
        send(1, 0, 0, got);
        send(0, -32768, 0, got);
        send(1, 0, 0, got);
        send(0, -32768, 0, got);
        check_val("sat_neg", got, -32768);
        send(1, 0, 0, got);

        // Random traffic with occasional long backpressure
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(7))
                0: delay = 12'd0;
                1: delay = 12'd1;
                2: delay = 12'd2048;
                3: delay = 12'd4095;
                4: delay = 12'd2047;
                default: delay = 12'($urandom_range(16, 1));
            endcase
            mix_gain = 8'($urandom_range(255));
            fb_gain  = 8'($urandom_range(255));
            bypass   = ($urandom_range(7) == 0);
            x0 = int'($urandom_range(65535)) - 32768;
            send(int'($urandom_range(1)), x0, (i % 10 == 5) ? 50 : 0, got);
        end
        bypass = 1'b0;

        // Reset while holding a result in OUT
        mix_gain = 8'd255; fb_gain = 8'd255; delay = 12'd1;
        n = 0;
        while (bus.i_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.o_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_channel = '0;
        bus.i_audio = 16'sd12345;
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 0;
        while (bus.o_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("midout_o_valid", int'(bus.o_valid), 1);
        reset_and_clear(1);
        for (int f = 0; f < 3; f++) begin
            send(0, 0, 0, got);
            check_val("post_rst_ch0", got, 0);
            send(1, 0, 0, got);
            check_val("post_rst_ch1", got, 0);
        end
        bypass = 1'b1;
        x0 = int'($urandom_range(65535)) - 32768;
        send(0, x0, 0, got);
        check_val("bypass_dry", got, x0);
        bypass = 1'b0;
        send(1, 0, 0, got);
        send(0, 0, 0, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
